// File: rtl/axis_hex_7seg_sink.sv
// rtl/axis_hex_7seg_sink.sv - stream sink showing each accepted word as hex on a multiplexed 7-segment display
module axis_hex_7seg_sink #(
    parameter int W           = 16,
    parameter int SCAN_DIV    = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [6:0]       seg,
    output logic [W/4-1:0]   an,
    output logic             busy
);

    localparam int DIGITS = W / 4;
    localparam int HW     = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int DW     = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam int IW     = (DIGITS < 2) ? 1 : $clog2(DIGITS);

    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] DIG_LAST  = IW'(DIGITS - 1);

    logic [W-1:0]  value;
    logic [HW-1:0] hold_cnt;
    logic [DW-1:0] div_cnt;
    logic [IW-1:0] dig_idx;
    logic [3:0]    nibble;

    // Ready only depends on registered hold state so it can never loop back through s_valid
    assign s_ready = !rst && (hold_cnt == '0);
    assign busy    = (hold_cnt != '0);

    // Capture a word on transfer and start the hold window; otherwise count the window down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value    <= '0;
            hold_cnt <= '0;
        end else if (s_valid && s_ready) begin
            value    <= s_data;
            hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Free-running digit scan, deliberately untouched by the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign an     = ~(DIGITS'(1) << dig_idx);
    assign nibble = value[4*dig_idx +: 4];

    // Active-low gfedcba decode of the selected nibble; every code maps to a glyph
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_axis_hex_7seg_sink.sv
// tb/tb_axis_hex_7seg_sink.sv - self-checking bench with behavioural display/handshake model
module tb_axis_hex_7seg_sink;

    localparam int HOLD_A = 8;
    localparam int SCAN_A = 4;
    localparam int HOLD_B = 0;
    localparam int SCAN_B = 1;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 0;
    logic rst = 1;

    logic [15:0] s_data_a = '0;
    logic        s_valid_a = 0;
    logic        s_ready_a, busy_a;
    logic [6:0]  seg_a;
    logic [3:0]  an_a;

    logic [7:0]  s_data_b = '0;
    logic        s_valid_b = 0;
    logic        s_ready_b, busy_b;
    logic [6:0]  seg_b;
    logic [1:0]  an_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axis_hex_7seg_sink #(.W(16), .SCAN_DIV(SCAN_A), .HOLD_CYCLES(HOLD_A)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data_a), .s_valid(s_valid_a),
        .s_ready(s_ready_a), .seg(seg_a), .an(an_a), .busy(busy_a)
    );

    axis_hex_7seg_sink #(.W(8), .SCAN_DIV(SCAN_B), .HOLD_CYCLES(HOLD_B)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid_b),
        .s_ready(s_ready_b), .seg(seg_b), .an(an_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since reset, time of last acceptance, and last accepted word
    int          n_a = 0, last_a = 0, n_b = 0, last_b = 0;
    logic        have_a = 0, have_b = 0;
    logic [15:0] val_a = '0;
    logic [7:0]  val_b = '0;
    logic        m_busy_a, m_busy_b, m_rdy_a, m_rdy_b;

    assign m_busy_a = have_a && ((n_a - last_a) < HOLD_A);
    assign m_busy_b = have_b && ((n_b - last_b) < HOLD_B);
    assign m_rdy_a  = !rst && !m_busy_a;
    assign m_rdy_b  = !rst && !m_busy_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_a <= 0; last_a <= 0; have_a <= 0; val_a <= '0;
            n_b <= 0; last_b <= 0; have_b <= 0; val_b <= '0;
        end else begin
            if (s_valid_a && m_rdy_a) begin
                val_a <= s_data_a; last_a <= n_a + 1; have_a <= 1;
            end
            if (s_valid_b && m_rdy_b) begin
                val_b <= s_data_b; last_b <= n_b + 1; have_b <= 1;
            end
            n_a <= n_a + 1;
            n_b <= n_b + 1;
        end
    end

    function automatic logic [3:0] exp_an_a();
        int d = (n_a / SCAN_A) % 4;
        logic [3:0] one = 4'b0001;
        return ~(one << d);
    endfunction

    function automatic logic [6:0] exp_seg_a();
        int d = (n_a / SCAN_A) % 4;
        return HEX[(val_a >> (4 * d)) & 16'hF];
    endfunction

    function automatic logic [1:0] exp_an_b();
        int d = (n_b / SCAN_B) % 2;
        logic [1:0] one = 2'b01;
        return ~(one << d);
    endfunction

    function automatic logic [6:0] exp_seg_b();
        int d = (n_b / SCAN_B) % 2;
        return HEX[(val_b >> (4 * d)) & 8'hF];
    endfunction

    // Every cycle, away from the active edge, compare both instances to the model
    always @(negedge clk) begin
        chk("a_ready", s_ready_a, m_rdy_a);
        chk("a_busy",  busy_a,    m_busy_a);
        chk("a_an",    an_a,      exp_an_a());
        chk("a_seg",   seg_a,     exp_seg_a());
        chk("b_ready", s_ready_b, m_rdy_b);
        chk("b_busy",  busy_b,    m_busy_b);
        chk("b_an",    an_b,      exp_an_b());
        chk("b_seg",   seg_b,     exp_seg_b());
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready_a(input string name);
        logic got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_ready_a) begin
                got = 1;
                break;
            end
        end
        chk(name, got, 1);
    endtask

    logic [3:0] scan_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial begin
        int   low_cnt, busy_cnt;
        logic seen;
        logic [3:0] prev_an;

        // 1. Reset
        rst = 1;
        repeat (3) @(negedge clk);
        chk("t1_rst_ready", s_ready_a, 0);
        chk("t1_rst_an",    an_a, 4'b1110);
        chk("t1_rst_seg",   seg_a, 7'b1000000);
        chk("t1_rst_busy",  busy_a, 0);
        drive_edge();
        rst = 0;
        @(negedge clk);
        chk("t1_release_ready", s_ready_a, 1);

        // 2. Single transfer and hold
        drive_edge();
        s_data_a = 16'h0006; s_valid_a = 1;
        drive_edge();
        s_valid_a = 0;
        low_cnt = 0; busy_cnt = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!s_ready_a) low_cnt++;
            if (busy_a) busy_cnt++;
            if (an_a == 4'b1110 && !seen) begin
                chk("t2_digit0_seg", seg_a, 7'b0000010);
                seen = 1;
            end
        end
        chk("t2_ready_low_cycles", low_cnt, 8);
        chk("t2_busy_cycles", busy_cnt, 8);
        chk("t2_digit0_seen", seen, 1);

        // 3. Backpressure: data changes while not ready are ignored
        drive_edge();
        s_data_a = 16'h0006; s_valid_a = 1;
        drive_edge();
        s_data_a = 16'h000A;
        repeat (4) drive_edge();
        s_data_a = 16'h000F;
        wait_ready_a("t3_wait_ready");
        drive_edge();
        s_valid_a = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an_a == 4'b1110) begin
                chk("t3_digit0_seg", seg_a, 7'b0001110);
                seen = 1;
                break;
            end
        end
        chk("t3_digit0_seen", seen, 1);

        // 4. Scan order on 0x1234
        wait_ready_a("t4_wait_ready");
        drive_edge();
        s_data_a = 16'h1234; s_valid_a = 1;
        drive_edge();
        s_valid_a = 0;
        seen = 0;
        prev_an = an_a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an_a == 4'b1110 && prev_an != 4'b1110) begin
                seen = 1;
                break;
            end
            prev_an = an_a;
        end
        chk("t4_scan_start_seen", seen, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_an_%0d", i), an_a, scan_an[i/4]);
            chk($sformatf("t4_seg_%0d", i), seg_a, scan_seg[i/4]);
            @(negedge clk);
        end
        chk("t4_wrap_an", an_a, 4'b1110);

        // 5. HOLD_CYCLES=0 instance streams back to back
        drive_edge();
        s_valid_b = 1; s_data_b = 8'h03;
        @(negedge clk); chk("t5_ready_w3", s_ready_b, 1);
        drive_edge();
        s_data_b = 8'h02;
        @(negedge clk); chk("t5_ready_w2", s_ready_b, 1);
        drive_edge();
        s_data_b = 8'h01;
        @(negedge clk); chk("t5_ready_w1", s_ready_b, 1);
        drive_edge();
        s_valid_b = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_busy", busy_b, 0);
            if (an_b == 2'b10) chk("t5_seg_lo", seg_b, 7'b1111001);
            else               chk("t5_seg_hi", seg_b, 7'b1000000);
        end

        // 6. Reset in the middle of a hold window
        wait_ready_a("t6_wait_ready");
        drive_edge();
        s_data_a = 16'hBEEF; s_valid_a = 1;
        drive_edge();
        s_valid_a = 0;
        repeat (2) drive_edge();
        rst = 1;
        #1;
        chk("t6_rst_ready", s_ready_a, 0);
        chk("t6_rst_busy",  busy_a, 0);
        chk("t6_rst_an",    an_a, 4'b1110);
        chk("t6_rst_seg",   seg_a, 7'b1000000);
        drive_edge();
        rst = 0;
        @(negedge clk);
        chk("t6_release_ready", s_ready_a, 1);
        chk("t6_release_busy",  busy_a, 0);

        // Randomized traffic with occasional resets, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            drive_edge();
            s_valid_a = 1'($urandom_range(0, 1));
            s_data_a  = 16'($urandom);
            s_valid_b = 1'($urandom_range(0, 1));
            s_data_b  = 8'($urandom);
            rst       = ($urandom_range(0, 149) == 0);
        end
        drive_edge();
        rst = 0; s_valid_a = 0; s_valid_b = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
